// File: rtl/fp_multi_lane_reduce.sv
// ---------------------------------------------------------------------------
// fp_multi_lane_reduce
//
// N-lane floating-point reduction sequencer. A start request captures N_CH
// operand words. In function mode (mode=0) each word is sent through its own
// external function lane (start/done handshake) and replaced by that lane's
// result. The lane words are then summed in a fixed left-to-right order,
// (((l0+l1)+l2)+...), through one shared multi-cycle external adder that
// uses an enable/done handshake. Bypass mode (mode=1) skips the function
// lanes.
//
// Ports
//   clk, reset_n     rising-edge clock, synchronous active-low reset
//   start, mode      request (sampled only while busy=0) and path select
//   data_in          N_CH packed operands, lane i = [i*W +: W]
//   busy, done       busy from accept through done; done is a 1-cycle pulse
//   result           final sum, held until the next accepted start
//   fu_start/fu_data per-lane start pulse and operand
//   fu_result/fu_done per-lane result and done (pulse or level)
//   add_en, add_a/b  adder enable and operands (stable while add_en=1)
//   add_result/done  adder sum and done
// ---------------------------------------------------------------------------
module fp_multi_lane_reduce #(
   parameter int N_CH = 4,
   parameter int W    = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              mode,
   input  logic [N_CH*W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic [W-1:0]      result,
   output logic [N_CH-1:0]   fu_start,
   output logic [N_CH*W-1:0] fu_data,
   input  logic [N_CH*W-1:0] fu_result,
   input  logic [N_CH-1:0]   fu_done,
   output logic              add_en,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   input  logic [W-1:0]      add_result,
   input  logic              add_done
);

   localparam int KW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_CH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FUNC,
      S_REDUCE,
      S_ADD,
      S_GAP,
      S_DONE
   } state_t;

   state_t            state;
   logic [N_CH*W-1:0] lane_reg;   // captured operands, later lane results
   logic [N_CH-1:0]   cap;        // lane result already captured
   logic [N_CH-1:0]   cap_next;
   logic [W-1:0]      acc;
   logic [KW-1:0]     k;          // index of the lane most recently added
   logic [KW-1:0]     op_idx;
   logic [W-1:0]      next_op;

   assign fu_data = lane_reg;

   always_comb begin
      // NOTE: every signal assigned here gets an unconditional value, so no
      // latch can be inferred.
      cap_next = cap | fu_done;
      // REDUCE loads lane 1 as the first addend; each GAP loads lane k+1.
      op_idx   = (state == S_REDUCE) ? KW'(1) : k + KW'(1);
      next_op  = lane_reg[int'(op_idx)*W +: W];
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // updates from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         // NOTE: the lane registers are flops, not a RAM, so resetting them
         // is cheap and keeps a post-abort result from leaking old data.
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         fu_start <= '0;
         add_en   <= 1'b0;
         result   <= '0;
         add_a    <= '0;
         add_b    <= '0;
         lane_reg <= '0;
         cap      <= '0;
         acc      <= '0;
         k        <= '0;
      end else begin
         done     <= 1'b0;
         fu_start <= '0;
         case (state)
            S_IDLE: begin
               // busy is still 1 during the done cycle, so a start there
               // is dropped; the next cycle accepts.
               busy <= 1'b0;
               if (start && !busy) begin
                  lane_reg <= data_in;
                  cap      <= '0;
                  busy     <= 1'b1;
                  if (mode) begin
                     state <= S_REDUCE;
                  end else begin
                     state    <= S_FUNC;
                     fu_start <= '1;
                  end
               end
            end

            S_FUNC: begin
               // fu_done is ignored during the fu_start cycle itself, so a
               // stale level from a previous run cannot be captured.
               if (!fu_start[0]) begin
                  for (int i = 0; i < N_CH; i++) begin
                     if (fu_done[i] && !cap[i]) begin
                        lane_reg[i*W +: W] <= fu_result[i*W +: W];
                     end
                  end
                  cap <= cap_next;
                  if (&cap_next) begin
                     state <= S_REDUCE;
                  end
               end
            end

            S_REDUCE: begin
               acc <= lane_reg[0 +: W];
               k   <= KW'(1);
               if (N_CH == 1) begin
                  state <= S_DONE;
               end else begin
                  add_a  <= lane_reg[0 +: W];
                  add_b  <= next_op;
                  add_en <= 1'b1;
                  state  <= S_ADD;
               end
            end

            S_ADD: begin
               if (add_done) begin
                  acc    <= add_result;
                  add_en <= 1'b0;
                  state  <= S_GAP;
               end
            end

            S_GAP: begin
               // One idle cycle with add_en low lets the adder drop add_done
               // before the next operand pair is presented.
               if (k == K_LAST) begin
                  state <= S_DONE;
               end else begin
                  k      <= k + KW'(1);
                  add_a  <= acc;
                  add_b  <= next_op;
                  add_en <= 1'b1;
                  state  <= S_ADD;
               end
            end

            S_DONE: begin
               result <= acc;
               done   <= 1'b1;
               state  <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_multi_lane_reduce.sv
// ---------------------------------------------------------------------------
// tb_fp_multi_lane_reduce
//
// Scoreboard bench. Directed stimulus pushes the expected result and the
// expected start-to-done latency for every run that must complete; a monitor
// pops and compares whenever done is seen. A 4-lane instance uses an adder
// model (La=3) and per-lane f(x)=2x models with programmable delays; a
// 1-lane instance covers the no-add case.
// Latency expectation: mode 1 = 2 + (N_CH-1)*(La+2); mode 0 adds
// (max lane delay + 1), lane delay counted from the cycle fu_start is seen
// high to the cycle fu_done is seen high.
// ---------------------------------------------------------------------------
module tb_fp_multi_lane_reduce;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int LA = 3;
   localparam int BYPASS_LAT = 2 + (N - 1) * (LA + 2);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-lane instance
   logic           reset_n;
   logic           start;
   logic           mode;
   logic [N*W-1:0] data_in;
   logic           busy;
   logic           done;
   logic [W-1:0]   result;
   logic [N-1:0]   fu_start;
   logic [N*W-1:0] fu_data;
   logic [N*W-1:0] fu_result;
   logic [N-1:0]   fu_done;
   logic           add_en;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic [W-1:0]   add_result;
   logic           add_done;

   // 1-lane instance
   logic           start_b;
   logic [W-1:0]   data_b;
   logic           busy_b;
   logic           done_b;
   logic [W-1:0]   result_b;
   logic [0:0]     fu_start_b;
   logic [W-1:0]   fu_data_b;
   logic           add_en_b;
   logic [W-1:0]   add_a_b;
   logic [W-1:0]   add_b_b;

   fp_multi_lane_reduce #(.N_CH(N), .W(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .data_in(data_in), .busy(busy), .done(done), .result(result),
      .fu_start(fu_start), .fu_data(fu_data), .fu_result(fu_result),
      .fu_done(fu_done), .add_en(add_en), .add_a(add_a), .add_b(add_b),
      .add_result(add_result), .add_done(add_done)
   );

   fp_multi_lane_reduce #(.N_CH(1), .W(W)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start_b), .mode(1'b1),
      .data_in(data_b), .busy(busy_b), .done(done_b), .result(result_b),
      .fu_start(fu_start_b), .fu_data(fu_data_b), .fu_result('0),
      .fu_done(1'b0), .add_en(add_en_b), .add_a(add_a_b), .add_b(add_b_b),
      .add_result('0), .add_done(1'b0)
   );

   // ---------------- float32 helpers (normal numbers and zero) -----------
   function automatic real f2d(input logic [31:0] x);
      logic [10:0] e;
      logic [63:0] b;
      if (x[30:0] == 31'd0) return 0.0;
      e = {3'b000, x[30:23]} + 11'd896;
      b = {x[31], e, x[22:0], 29'd0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] d2f(input real r);
      logic [63:0] b;
      logic [10:0] e;
      b = $realtobits(r);
      if (b[62:0] == 63'd0) return 32'd0;
      e = b[62:52] - 11'd896;
      return {b[63], e[7:0], b[51:29]};
   endfunction

   // ---------------- adder model: add_done La cycles after add_en rises --
   int acnt = 0;
   always @(posedge clk) begin
      if (!add_en) acnt <= 0;
      else         acnt <= acnt + 1;
   end
   always_comb begin
      add_done   = add_en && (acnt >= LA);
      add_result = d2f(f2d(add_a) + f2d(add_b));
   end

   // ---------------- lane models: f(x)=2x, delay and hold per lane -------
   int lane_delay [N];
   int hold_len;
   int lcnt [N];
   bit lact [N];
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (fu_start[i]) begin
            lact[i] <= 1'b1;
            lcnt[i] <= 1;
         end else if (lact[i]) begin
            lcnt[i] <= lcnt[i] + 1;
            if (lcnt[i] >= lane_delay[i] + hold_len - 1) lact[i] <= 1'b0;
         end
      end
   end
   always_comb begin
      fu_done   = '0;
      fu_result = '0;
      for (int i = 0; i < N; i++) begin
         fu_done[i] = lact[i] && (lcnt[i] >= lane_delay[i]) &&
                      (lcnt[i] < lane_delay[i] + hold_len);
         fu_result[i*W +: W] = d2f(2.0 * f2d(fu_data[i*W +: W]));
      end
   end

   // ---------------- scoreboard ------------------------------------------
   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;
   exp_t q4[$];
   exp_t q1[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   int cyc = 0;
   int acc_cyc4 = 0;
   int acc_cyc1 = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset_n && start && !busy)     acc_cyc4 <= cyc + 1;
      if (reset_n && start_b && !busy_b) acc_cyc1 <= cyc + 1;
   end

   int   n_done4 = 0;
   int   n_done1 = 0;
   int   n_fu_start = 0;
   int   n_burst = 0;
   int   n_add1 = 0;
   int   last_fu_done_cyc = -1;
   int   first_add_rise = -1;
   int   fall_cyc = 0;
   bit   fall_valid = 1'b0;
   logic add_en_q = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (fu_start != '0) begin
            n_fu_start++;
            check("fu_start_all_lanes", 64'(fu_start), 64'hF);
         end
         if (fu_done != '0) last_fu_done_cyc = cyc;
         if (add_en && !add_en_q) begin
            n_burst++;
            if (first_add_rise < 0) first_add_rise = cyc;
            if (fall_valid) check("add_gap_cycles", 64'(cyc - fall_cyc), 64'd1);
         end
         if (!add_en && add_en_q) begin
            fall_cyc   = cyc;
            fall_valid = 1'b1;
         end
         if (add_en_b) n_add1++;
         if (done) begin
            n_done4++;
            fall_valid = 1'b0;
            check("busy_during_done", 64'(busy), 64'd1);
            if (q4.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = q4.pop_front();
               check("result", 64'(result), 64'(e.res));
               check("latency", 64'(cyc - acc_cyc4), 64'(e.lat));
            end
         end
         if (done_b) begin
            n_done1++;
            if (q1.size() == 0) begin
               check("unexpected_done_1lane", 64'd1, 64'd0);
            end else begin
               e = q1.pop_front();
               check("result_1lane", 64'(result_b), 64'(e.res));
               check("latency_1lane", 64'(cyc - acc_cyc1), 64'(e.lat));
            end
         end
      end
      add_en_q = add_en;
   end

   // ---------------- stimulus --------------------------------------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic m, input logic [N*W-1:0] d);
      tick();
      start   = 1'b1;
      mode    = m;
      data_in = d;
      tick();
      start   = 1'b0;
   endtask

   task automatic issue_b(input logic [W-1:0] d);
      tick();
      start_b = 1'b1;
      data_b  = d;
      tick();
      start_b = 1'b0;
   endtask

   task automatic wait_done(input bit which, input int budget);
      int  snap;
      bit  seen;
      snap = which ? n_done1 : n_done4;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if ((which ? n_done1 : n_done4) != snap) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("done_timeout", 64'd0, 64'd1);
   endtask

   // lane 0 is the least significant word
   localparam logic [N*W-1:0] D_1234 =
      {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
   localparam logic [N*W-1:0] D_2222 =
      {32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
   localparam logic [N*W-1:0] D_5500 =
      {32'h00000000, 32'h00000000, 32'h40A00000, 32'h40A00000};

   int s_fs, s_b, s_d;

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      mode       = 1'b0;
      data_in    = '0;
      start_b    = 1'b0;
      data_b     = '0;
      hold_len   = 1;
      lane_delay = '{3, 5, 7, 1};

      // Reset state
      repeat (3) tick();
      check("rst_busy",     64'(busy),     64'd0);
      check("rst_done",     64'(done),     64'd0);
      check("rst_result",   64'(result),   64'd0);
      check("rst_fu_start", 64'(fu_start), 64'd0);
      check("rst_fu_data",  64'(fu_data[63:0]), 64'd0);
      check("rst_add_en",   64'(add_en),   64'd0);
      check("rst_add_ab",   {add_a, add_b}, 64'd0);
      check("rst_busy_1lane",   64'(busy_b),   64'd0);
      check("rst_result_1lane", 64'(result_b), 64'd0);
      reset_n = 1'b1;
      tick();

      // Bypass sum: 1+2+3+4 = 10.0
      s_fs = n_fu_start; s_b = n_burst;
      q4.push_back('{32'h41200000, BYPASS_LAT});
      issue(1'b1, D_1234);
      wait_done(1'b0, 100);
      check("t1_fu_start_pulses", 64'(n_fu_start - s_fs), 64'd0);
      check("t1_add_bursts",      64'(n_burst - s_b),     64'd3);

      // Function path, out-of-order lanes (delays 3,5,7,1): 2+4+6+8 = 20.0
      lane_delay = '{3, 5, 7, 1};
      first_add_rise = -1; last_fu_done_cyc = -1;
      s_fs = n_fu_start; s_b = n_burst;
      q4.push_back('{32'h41A00000, BYPASS_LAT + 7 + 1});
      issue(1'b0, D_1234);
      wait_done(1'b0, 100);
      check("t2_fu_start_pulses", 64'(n_fu_start - s_fs), 64'd1);
      check("t2_add_bursts",      64'(n_burst - s_b),     64'd3);
      check("t2_add_after_last_fu_done",
            64'(first_add_rise - last_fu_done_cyc), 64'd2);

      // Level fu_done on all lanes together, held 10 cycles
      lane_delay = '{2, 2, 2, 2};
      hold_len   = 10;
      s_b = n_burst; s_d = n_done4;
      q4.push_back('{32'h41A00000, BYPASS_LAT + 2 + 1});
      issue(1'b0, D_1234);
      wait_done(1'b0, 100);
      repeat (12) tick();
      check("t3_add_bursts", 64'(n_burst - s_b), 64'd3);
      check("t3_single_done", 64'(n_done4 - s_d), 64'd1);
      hold_len = 1;

      // Start while busy is ignored; start right after done is accepted
      s_d = n_done4;
      q4.push_back('{32'h41200000, BYPASS_LAT});
      issue(1'b1, D_1234);
      repeat (4) tick();
      issue(1'b1, D_2222);
      wait_done(1'b0, 100);
      check("t4_first_done_once", 64'(n_done4 - s_d), 64'd1);
      q4.push_back('{32'h41000000, BYPASS_LAT});
      issue(1'b1, D_2222);
      wait_done(1'b0, 100);
      check("t4_second_accepted", 64'(n_done4 - s_d), 64'd2);

      // Reset mid-FUNC with lanes 1 and 2 still pending
      lane_delay = '{3, 5, 7, 1};
      s_d = n_done4; s_b = n_burst;
      issue(1'b0, D_1234);
      repeat (4) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (12) tick();
      check("t5_busy_after_abort",   64'(busy),   64'd0);
      check("t5_result_after_abort", 64'(result), 64'd0);
      check("t5_no_done",            64'(n_done4 - s_d), 64'd0);
      check("t5_no_add",             64'(n_burst - s_b), 64'd0);
      q4.push_back('{32'h41200000, BYPASS_LAT});
      issue(1'b1, D_5500);
      wait_done(1'b0, 100);

      // Single-lane build: result is the operand itself, no adds
      s_b = n_add1;
      q1.push_back('{32'h40490FDB, 2});
      issue_b(32'h40490FDB);
      wait_done(1'b1, 50);
      check("t6_no_add_1lane", 64'(n_add1 - s_b), 64'd0);

      repeat (3) tick();
      check("scoreboard_drained", 64'(q4.size() + q1.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
